// File: rtl/wb_write_buffer.sv
// Writeback queue in front of the register bank write port.
// Drains in FIFO order and offers youngest-value bypass lookups.
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_data,
    input  logic          drain_en,
    output logic          rf_wr,
    output logic [4:0]    rf_rd,
    output logic [31:0]   rf_wd,
    input  logic [4:0]    lk_rs1,
    input  logic [4:0]    lk_rs2,
    output logic          lk1_hit,
    output logic [31:0]   lk1_data,
    output logic          lk2_hit,
    output logic [31:0]   lk2_data,
    output logic [AW:0]   count
);

    logic [DEPTH-1:0] vld;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty    = (cnt == '0);
    assign in_ready = (cnt != (AW+1)'(DEPTH));
    // r0 writes complete the handshake but never occupy an entry
    assign push     = in_valid & in_ready & (in_rd != 5'd0);
    assign pop      = rf_wr;

    assign rf_wr = ~empty & drain_en;
    assign rf_rd = empty ? 5'd0  : rd_q[rptr];
    assign rf_wd = empty ? 32'd0 : data_q[rptr];
    assign count = cnt;

    // Scan oldest to youngest so the last match is the youngest one
    function automatic logic [32:0] lookup(input logic [4:0] rs);
        logic [AW-1:0] idx;
        logic [32:0]   res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + i[AW-1:0];
            if (vld[idx] && rd_q[idx] == rs && rs != 5'd0)
                res = {1'b1, data_q[idx]};
        end
        return res;
    endfunction

    always_comb begin
        {lk1_hit, lk1_data} = lookup(lk_rs1);
        {lk2_hit, lk2_data} = lookup(lk_rs2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            if (push) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= in_rd;
            data_q[wptr] <= in_data;
        end
    end

endmodule

// File: doc/wb_write_buffer.md
Name: wb_write_buffer

Overview:
- Writer-side front end for the 32x32 register bank.
- Accepts writeback requests (rd, data) from multi-cycle units (load, multiply), queues them in a small FIFO, and drains one entry per enabled cycle into the bank's single write port (wr/rd/rd_in).
- Provides two combinational bypass lookups so the decode stage sees the youngest pending value of a register before it reaches the bank.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  writeback request present.
- in_ready  out  1  queue can accept a request this cycle.
- in_rd  in  5  destination register index.
- in_data  in  32  writeback value.
- drain_en  in  1  bank write permitted this cycle (0 = hold queue).
- rf_wr  out  1  write strobe to register bank.
- rf_rd  out  5  write index to register bank.
- rf_wd  out  32  write data to register bank.
- lk_rs1  in  5  bypass lookup index, port 1.
- lk_rs2  in  5  bypass lookup index, port 2.
- lk1_hit  out  1  a pending entry matches lk_rs1.
- lk1_data  out  32  youngest pending value for lk_rs1; 0 when no hit.
- lk2_hit  out  1  a pending entry matches lk_rs2.
- lk2_data  out  32  youngest pending value for lk_rs2; 0 when no hit.
- count  out  AW+1  number of occupied entries.

Behaviour:
- Storage: DEPTH entries of {valid, rd[4:0], data[31:0]}, a write pointer, a read pointer and a count.
- Reset (async, rst_n=0):
  - Pointers, count and all valid bits go to 0 immediately.
  - Outputs at reset: in_ready=1, rf_wr=0, rf_rd=0, rf_wd=0, lk*_hit=0, lk*_data=0, count=0.
  - Entry data contents are don't-care.
  - A reset mid-drain discards all pending entries; no partial write is issued.
- Push:
  - Handshake occurs when in_valid & in_ready at a rising edge.
  - in_ready = (count != DEPTH). It is derived from current occupancy only; it does not credit a same-cycle pop.
- r0 filter: a handshake with in_rd == 0 is accepted but not enqueued. Count and pointers are unchanged, so register 0 is never written.
- Drain outputs (combinational from the head entry):
  - rf_wr = (count != 0) & drain_en.
  - rf_rd = head rd, rf_wd = head data when count != 0; both are 0 when empty.
- Pop: at the rising edge where rf_wr=1, the head is invalidated and the read pointer advances.
- Latency: a request accepted at edge N into an empty queue with drain_en=1 presents rf_wr=1 during cycle N..N+1 and is written into the bank at edge N+1.
- Simultaneous push and pop: both take effect and count is unchanged.
  - Push into a full queue is blocked even if a pop occurs in the same cycle.
  - Push into an empty queue is never written to the bank in the same edge.
- Pointers wrap modulo DEPTH.
- Order: drain is strictly FIFO. Multiple entries for the same rd are all written in arrival order.
- Bypass:
  - lkN_hit = 1 if any valid entry has rd == lk_rsN and lk_rsN != 0.
  - lkN_data = data of the youngest matching entry (nearest the write pointer).
  - Purely combinational from registered state; the same-cycle incoming request is not visible.
  - Lookup of index 0 always returns hit=0, data=0.
- drain_en=0: queue holds, rf_wr=0, and pushes continue until full.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> count=0, in_ready=1, rf_wr=0 immediately, with no clock edge required.
- Single write: push rd=5, data=0xDEADBEEF with drain_en=1 -> next cycle rf_wr=1, rf_rd=5, rf_wd=0xDEADBEEF; after the following edge, count=0.
- Fill/backpressure: drain_en=0, push rd=1..4 with data 0x11..0x44 -> count=4, in_ready=0, and a fifth push (rd=6) is not accepted. Raise drain_en -> writes of 1, 2, 3, 4 in order on 4 consecutive edges, with in_ready=1 after the first pop.
- Bypass youngest: drain_en=0, push (7, 0xA), then (7, 0xB), then (3, 0xC). Set lk_rs1=7, lk_rs2=3 -> lk1_hit=1, lk1_data=0xB; lk2_hit=1, lk2_data=0xC. Set lk_rs1=9 -> lk1_hit=0, lk1_data=0.
- r0 filter: push rd=0, data=0xFFFFFFFF -> in_ready=1 during the handshake, count stays 0, rf_wr never asserts, and lk_rs1=0 gives hit=0.
- Simultaneous push/pop and wrap: DEPTH=4, drain_en=1, stream 10 back-to-back pushes rd=1..10 (mod 32) -> count never exceeds 1, pointers wrap twice, and the bank sees all 10 writes in order with matching data. Assert rst_n=0 with 2 entries pending -> no further rf_wr.
